// File: rtl/pattern_pkg.sv
// -----------------------------------------------------------------------------
// pattern_pkg
// Definitions shared by the pattern transmitter and the fixed-pattern detector:
//   - FSM state encoding (IDLE/SEND/GAP/DONE)
//   - default pattern and its length
//   - filler LFSR seed and feedback taps, plus the one-step update function
// -----------------------------------------------------------------------------
package pattern_pkg;

    localparam int                   PAT_W_DEF   = 11;
    localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 11'b10110110110;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Feedback taps at bits 7, 5, 4 and 3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SEND = 2'd1;
    localparam state_t ST_GAP  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // One shift of the filler LFSR: shift left, XOR of the taps enters at bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pattern_gen_lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// 8-bit Fibonacci LFSR used as the source of random filler bits.
// Seeded only by reset; advances one step on every clock with en=1.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous reset, active-low (reloads the seed)
//   en            in   advance the register at this edge
//   fill_bit_nxt  out  MSB the register will hold after this edge, so the
//                      parent can register it into its serial output in step
//                      with the shift
// -----------------------------------------------------------------------------
module lfsr8 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic fill_bit_nxt
);
    import pattern_pkg::*;

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = en ? lfsr_step(lfsr_q) : lfsr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign fill_bit_nxt = lfsr_d[7];

endmodule

// File: rtl/pattern_gen.sv
// -----------------------------------------------------------------------------
// pattern_gen
// Serial pattern transmitter. On start it sends PATTERN MSB-first repeat_cnt
// times, with gap_len filler bits (zeros or LFSR bits) between repetitions,
// and counts completed patterns in sent_cnt.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active-low
//   start       in   begin a transfer (only honoured when idle)
//   abort       in   stop the transfer at the next edge (SEND/GAP only)
//   repeat_cnt  in   number of patterns, latched at start
//   gap_len     in   filler bits between patterns, latched at start
//   fill_rand   in   filler source: 0 = zeros, 1 = LFSR; latched at start
//   data_out    out  registered serial bit
//   data_valid  out  data_out carries a pattern or filler bit
//   pat_start   out  high on the first bit of every pattern
//   busy        out  transfer in progress (SEND, GAP, DONE)
//   done        out  one-cycle pulse after the final pattern bit
//   sent_cnt    out  patterns fully sent in the current/last transfer
// -----------------------------------------------------------------------------
module pattern_gen
    import pattern_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
    parameter int               CNT_W   = 8,
    parameter int               GAP_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             fill_rand,
    output logic             data_out,
    output logic             data_valid,
    output logic             pat_start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_cnt
);

    localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    state_t           state_q,     state_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic [GAP_W-1:0] gap_q,       gap_d;
    logic [CNT_W-1:0] rep_q,       rep_d;
    logic [GAP_W-1:0] gap_len_q,   gap_len_d;
    logic             fill_rand_q, fill_rand_d;
    logic [CNT_W-1:0] sent_cnt_d;
    logic             fill_bit_nxt;
    logic             lfsr_en;

    // The LFSR steps once per GAP cycle when random filler is selected.
    assign lfsr_en = (state_q == ST_GAP) && fill_rand_q;

    lfsr8 u_lfsr (
        .clk          (clk),
        .rst          (rst),
        .en           (lfsr_en),
        .fill_bit_nxt (fill_bit_nxt)
    );

    // Next-state and counter logic. rep_q holds the patterns still to send,
    // including the one currently in SEND.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        rep_d       = rep_q;
        gap_len_d   = gap_len_q;
        fill_rand_d = fill_rand_q;
        sent_cnt_d  = sent_cnt;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rep_d       = repeat_cnt;
                    gap_len_d   = gap_len;
                    fill_rand_d = fill_rand;
                    sent_cnt_d  = '0;
                    idx_d       = IDX_TOP;
                    state_d     = (repeat_cnt == '0) ? ST_DONE : ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (idx_q == '0) begin
                    sent_cnt_d = sent_cnt + CNT_W'(1);
                    rep_d      = rep_q - CNT_W'(1);
                    idx_d      = IDX_TOP;
                    if (rep_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else if (gap_len_q != '0) begin
                        state_d = ST_GAP;
                        gap_d   = gap_len_q;
                    end
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (gap_q == GAP_W'(1)) begin
                    state_d = ST_SEND;
                    idx_d   = IDX_TOP;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so the first pattern bit
    // appears in the cycle right after start is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            gap_q       <= '0;
            rep_q       <= '0;
            gap_len_q   <= '0;
            fill_rand_q <= 1'b0;
            sent_cnt    <= '0;
            data_out    <= 1'b0;
            data_valid  <= 1'b0;
            pat_start   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            rep_q       <= rep_d;
            gap_len_q   <= gap_len_d;
            fill_rand_q <= fill_rand_d;
            sent_cnt    <= sent_cnt_d;
            data_valid  <= (state_d == ST_SEND) || (state_d == ST_GAP);
            pat_start   <= (state_d == ST_SEND) && (idx_d == IDX_TOP);
            busy        <= (state_d != ST_IDLE);
            done        <= (state_d == ST_DONE);
            case (state_d)
                ST_SEND: data_out <= PATTERN[idx_d];
                ST_GAP:  data_out <= fill_rand_d & fill_bit_nxt;
                default: data_out <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_pattern_gen
// Scoreboard bench for pattern_gen. Each transfer's expected bit stream is
// built from the pattern/gap/filler rules and queued before start is driven;
// a negedge monitor pops and compares whenever data_valid or done is seen.
// -----------------------------------------------------------------------------
module tb_pattern_gen;

    localparam int          PAT_W = 11;
    localparam logic [10:0] PAT   = 11'b10110110110;
    localparam int          CNT_W = 8;
    localparam int          GAP_W = 4;

    logic             clk        = 1'b0;
    logic             rst        = 1'b0;
    logic             start      = 1'b0;
    logic             abort      = 1'b0;
    logic             fill_rand  = 1'b0;
    logic [CNT_W-1:0] repeat_cnt = '0;
    logic [GAP_W-1:0] gap_len    = '0;
    logic             data_out;
    logic             data_valid;
    logic             pat_start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent_cnt;

    pattern_gen #(
        .PAT_W   (PAT_W),
        .PATTERN (PAT),
        .CNT_W   (CNT_W),
        .GAP_W   (GAP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .repeat_cnt (repeat_cnt),
        .gap_len    (gap_len),
        .fill_rand  (fill_rand),
        .data_out   (data_out),
        .data_valid (data_valid),
        .pat_start  (pat_start),
        .busy       (busy),
        .done       (done),
        .sent_cnt   (sent_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Scoreboard: expected {data_out, pat_start} per valid cycle, and the
    // expected cycle id / sent count of each done pulse.
    logic [1:0] exp_q[$];
    int         done_id_q[$];
    int         done_cnt_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] m_lfsr = 8'hA5;
    logic [1:0] mon_e;

    function automatic logic [7:0] model_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            check("reset_outputs", {data_out, data_valid, pat_start, busy, done, sent_cnt}, 0);
        end else begin
            if (data_valid) begin
                check("busy_while_valid", busy, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid_bit", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data_out", data_out, mon_e[1]);
                    check("pat_start", pat_start, mon_e[0]);
                end
            end else begin
                check("idle_data_out_pat_start", {data_out, pat_start}, 0);
            end
            if (done) begin
                check("valid_at_done", data_valid, 0);
                if (done_id_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("done_cycle", cyc, done_id_q.pop_front());
                    check("done_sent_cnt", sent_cnt, done_cnt_q.pop_front());
                    check("busy_at_done", busy, 1);
                end
            end
        end
    end

    // Called and returns at #1 after a rising edge.
    task automatic do_reset(input int hold);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        exp_q.delete();
        done_id_q.delete();
        done_cnt_q.delete();
        m_lfsr = 8'hA5;
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_busy", busy, 0);
        check("post_reset_valid", data_valid, 0);
        check("post_reset_sent_cnt", sent_cnt, 0);
    endtask

    // kind 0: normal transfer (optionally with a start pulse while busy)
    // kind 1: abort during stream bit pos (pos < 0: random non-final bit)
    // kind 2: reset asserted before stream bit pos is shown
    // Called at #1 after a rising edge; returns at #1 after a rising edge,
    // for kind 0 in the first idle cycle after done.
    task automatic run_tx(input int r, input int g, input bit fill,
                          input int kind, input int pos, input bit poke);
        logic [1:0] s_bits[$];
        bit         s_last[$];
        bit         s_fill[$];
        logic [7:0] l;
        int         n, a, b, k, cnt, nfill, p;

        l = m_lfsr;
        for (int i = 0; i < r; i++) begin
            for (int j = PAT_W - 1; j >= 0; j--) begin
                s_bits.push_back({PAT[j], (j == PAT_W - 1)});
                s_last.push_back(j == 0);
                s_fill.push_back(1'b0);
            end
            if (i < r - 1) begin
                for (int q = 0; q < g; q++) begin
                    s_bits.push_back({(fill ? l[7] : 1'b0), 1'b0});
                    s_last.push_back(1'b0);
                    s_fill.push_back(fill);
                    if (fill) l = model_step(l);
                end
            end
        end
        n = s_bits.size();
        if (n == 0) kind = 0;

        b = 0;
        a = n;
        if (kind == 1) begin
            if (pos >= 0) b = pos;
            else begin
                b = $urandom_range(0, n - 1);
                while (s_last[b]) b = $urandom_range(0, n - 1);
            end
            a = b + 1;
        end else if (kind == 2) begin
            b = (pos >= 1) ? pos : 1;
            a = b;
        end

        cnt   = 0;
        nfill = 0;
        for (int i = 0; i < a; i++) begin
            exp_q.push_back(s_bits[i]);
            cnt   += int'(s_last[i]);
            nfill += int'(s_fill[i]);
        end
        if (kind == 0) m_lfsr = l;
        else if (kind == 1) for (int i = 0; i < nfill; i++) m_lfsr = model_step(m_lfsr);

        start      = 1'b1;
        repeat_cnt = CNT_W'(r);
        gap_len    = GAP_W'(g);
        fill_rand  = fill;
        k          = cyc + 1;
        if (kind == 0) begin
            done_id_q.push_back(k + n);
            done_cnt_q.push_back(cnt);
        end
        @(posedge clk);
        #1;
        start      = 1'b0;
        repeat_cnt = CNT_W'($urandom_range(0, 255));
        gap_len    = GAP_W'($urandom_range(0, 15));
        fill_rand  = 1'($urandom_range(0, 1));

        if (kind == 0) begin
            if (poke) begin
                p = $urandom_range(0, n);
                repeat (p) @(posedge clk);
                if (p > 0) #1;
                start      = 1'b1;
                repeat_cnt = CNT_W'($urandom_range(1, 5));
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            while (cyc < k + n + 1) begin
                @(posedge clk);
                #1;
            end
            check("queue_drained", exp_q.size(), 0);
            check("done_seen", done_id_q.size(), 0);
            check("busy_after_done", busy, 0);
            check("sent_cnt_final", sent_cnt, cnt);
        end else if (kind == 1) begin
            repeat (b) @(posedge clk);
            if (b > 0) #1;
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            check("abort_valid_low", data_valid, 0);
            check("abort_busy_low", busy, 0);
            check("abort_sent_cnt", sent_cnt, cnt);
            repeat (2) @(posedge clk);
            #1;
            check("abort_queue_drained", exp_q.size(), 0);
        end else begin
            repeat (b - 1) @(posedge clk);
            do_reset(3);
        end
    endtask

    initial begin
        do_reset(4);
        check("idle_busy", busy, 0);

        run_tx(1, 0, 1'b0, 0, 0, 1'b0);
        run_tx(3, 2, 1'b0, 0, 0, 1'b0);
        do_reset(2);
        run_tx(2, 3, 1'b1, 0, 0, 1'b0);
        run_tx(0, 5, 1'b0, 0, 0, 1'b0);
        run_tx(2, 0, 1'b0, 0, 0, 1'b1);
        run_tx(3, 0, 1'b0, 1, 5, 1'b0);
        run_tx(1, 0, 1'b0, 0, 0, 1'b0);
        run_tx(3, 4, 1'b1, 2, 14, 1'b0);
        run_tx(2, 3, 1'b1, 0, 0, 1'b0);
        run_tx(255, 0, 1'b0, 0, 0, 1'b0);
        run_tx(3, 15, 1'b1, 0, 0, 1'b0);
        run_tx(4, 3, 1'b1, 1, 30, 1'b0);

        for (int t = 0; t < 40; t++) begin
            int r, g, kd;
            bit f;
            r  = $urandom_range(0, 6);
            g  = $urandom_range(0, 15);
            f  = 1'($urandom_range(0, 1));
            kd = (r > 0 && $urandom_range(0, 3) == 0) ? 1 : 0;
            run_tx(r, g, f, kd, -1, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
